key_conditioner: RTL
====================

# key_conditioner

Conditions the 17 raw whack-a-mole hole buttons before they reach the game core. It does three things: synchronises the raw buttons, debounces each one on a shared sample tick, and turns each clean press into a single-cycle one-hot hit pulse. Its `key` output feeds the game's `key[16:0]` input directly, so the score logic sees exactly one hit per physical press.

## Interface
Parameters:
- TICK_DIV, default 50000: clk cycles per debounce sample tick (1 ms at 50 MHz); must be ≥2.
- DB_SAMPLES, default 10: number of consecutive differing samples needed to flip a debounced level; must be ≥1.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- key_raw  input  17  raw buttons, active-high, asynchronous to clk.
- key  output  17  hit pulses, one-hot or zero, one clk cycle wide.
- key_level  output  17  debounced button levels.
- multi_hit  output  1  one-cycle flag: more than one key rose in the same cycle.

## Operation
- **Synchroniser:** each key_raw bit passes through a 2-flop synchroniser, giving `s[i]`.
- **Tick generator:** a divider counts 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when the count equals TICK_DIV-1.
- **Per-key debounce:** on each tick, key i acts as follows.
  - If `s[i]` equals `key_level[i]`: the stable counter clears.
  - Otherwise the stable counter increments. When it reaches DB_SAMPLES, `key_level[i]` inverts and the counter clears in the same cycle.
  - Between ticks, level and counter hold.
- **Edge detection:** `rise[i]` = `key_level[i]` is high now and was low on the previous cycle.
- **Arbitration:** if several bits of `rise` are set in one cycle, only the lowest-index one produces a pulse. The others are dropped permanently, with no retry. `multi_hit` pulses in that same cycle.
- **Release:** falling levels never produce pulses.
- Counter width: clog2(DB_SAMPLES+1). Divider width: clog2(TICK_DIV).

## Timing
- **Reset values:** `key`=0, `key_level`=0, `multi_hit`=0. Divider, stable counters and synchroniser flops are all 0.
- **Reset mid-operation:** everything clears immediately. A button held through reset release is seen as a new press after DB_SAMPLES ticks.
- **Latency:**
  - A raw change that is stable from cycle t reaches `s` at t+2.
  - `key_level` flips on the DB_SAMPLES-th tick at or after t+2.
  - `key` pulses on the cycle after `key_level` rises.
- **Glitch rejection:** a bounce shorter than DB_SAMPLES consecutive ticks never changes `key_level`.
- **Pulse width:** `key` is never high for two consecutive cycles on the same bit. Back-to-back pulses on different bits are allowed.
- **Simultaneous events:** a tick coinciding with divider wrap is the normal case; no special handling.

## Configuration
- **KEY_LOCKOUT_EN defined:** while any `key_level` bit is high, rising edges on all other keys are suppressed. They produce neither a `key` pulse nor `multi_hit`. A suppressed key that is still held when lockout ends does not pulse; it must be released and pressed again.
- **KEY_LOCKOUT_EN undefined:** every key is independent, subject only to the same-cycle arbitration above.

## Structure
- **Shared package `hitegg_pkg`:** holds NUM_KEYS=17 and the key-vector width. The game core and random position generator use the same constant.
- **Sub-module `key_debounce_bit`:** one instance per key, generated NUM_KEYS times. It contains the synchroniser, stable counter and level register, and takes `tick` as an input.
- **Top level:** owns the divider, edge detection, arbitration and lockout.

## Test plan
Bench parameters: TICK_DIV=4, DB_SAMPLES=3.
- **Reset:** assert rst with key_raw=17'h1FFFF -> all outputs 0. Release rst and hold the buttons -> key_level=17'h1FFFF after 3 ticks; key=17'h00001 for one cycle; multi_hit=1 in that cycle.
- **Single press:** key_raw[5] goes high and is held -> key_level[5] rises on the 3rd tick after sync; key=17'h00020 for exactly one cycle. Release -> key_level[5] falls after 3 ticks with no pulse.
- **Bounce rejection:** key_raw[9] toggles every 6 cycles (under 3 ticks stable) for 100 cycles -> key_level and key stay 0.
- **Same-cycle press:** key_raw[3] and key_raw[12] rise on the same cycle -> key=17'h00008 once; multi_hit=1; key[12] never pulses.
- **Lockout (KEY_LOCKOUT_EN):** hold key 2, then press key 7 -> only key[2] pulses. Release key 2 while key 7 stays held -> no pulse. Release and re-press key 7 -> key[7] pulses.
- **Reset mid-debounce:** assert rst after 2 of the 3 samples -> counter clears; a fresh 3 ticks are needed after release.

Source files
------------

// File: rtl/hitegg_pkg.sv
// hitegg_pkg: constants and helpers shared by the whack-a-mole blocks.
// NUM_KEYS is the hole count; the game core, the random position generator
// and the key conditioner all size their key vectors from it.
package hitegg_pkg;

   localparam int NUM_KEYS = 17;
   localparam int KEY_W    = NUM_KEYS;

   typedef logic [KEY_W-1:0] key_vec_t;

   localparam key_vec_t KEY_ONE = key_vec_t'(1);

   // Isolates the lowest set bit (two's-complement trick): v & -v.
   function automatic key_vec_t lowest_set(input key_vec_t v);
      return v & (~v + KEY_ONE);
   endfunction

   // True when v has two or more bits set: clearing the lowest one leaves
   // something behind.
   function automatic logic more_than_one(input key_vec_t v);
      return (v & (v - KEY_ONE)) != '0;
   endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// key_debounce_bit: conditions one raw button.
//   - 2-flop synchroniser for the asynchronous raw input
//   - stable counter sampled on the shared debounce tick
//   - debounced level register, flipped after DB_SAMPLES consecutive
//     ticks on which the synchronised input differs from the level
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   tick     one-cycle debounce sample strobe from the shared divider
//   key_raw  raw button, asynchronous to clk
//   level    debounced button level
module key_debounce_bit #(
   parameter int DB_SAMPLES = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic key_raw,
   output logic level
);

   localparam int CNT_W = $clog2(DB_SAMPLES + 1);

   logic [1:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             s;

   assign s = sync_q[1];

   always_comb begin
      // NOTE: every signal gets a default before any branch so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      sync_d  = {sync_q[0], key_raw};
      cnt_d   = cnt_q;
      level_d = level_q;
      if (tick) begin
         if (s == level_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_W'(DB_SAMPLES - 1)) begin
            // This tick is the DB_SAMPLES-th differing sample.
            level_d = ~level_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: turns the raw hole buttons into clean one-hot hit pulses.
// Owns the debounce tick divider, rising-edge detection, same-cycle
// arbitration (lowest index wins, others dropped) and optional lockout.
// Build option: define KEY_LOCKOUT_EN to suppress presses on any key while
// another key's debounced level is high.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   key_raw    raw buttons, active-high, asynchronous
//   key        one-cycle hit pulses, one-hot or zero
//   key_level  debounced button levels
//   multi_hit  one-cycle flag: more than one key rose in the same cycle
module key_conditioner
   import hitegg_pkg::*;
#(
   parameter int TICK_DIV   = 50000,
   parameter int DB_SAMPLES = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_raw,
   output logic [KEY_W-1:0] key,
   output logic [KEY_W-1:0] key_level,
   output logic             multi_hit
);

   localparam int DIV_W = $clog2(TICK_DIV);

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;
   key_vec_t         level;
   key_vec_t         level_prev_q, level_prev_d;
   key_vec_t         key_q, key_d;
   logic             multi_q, multi_d;
   key_vec_t         rise;
   key_vec_t         cand;

   assign tick = (div_q == DIV_W'(TICK_DIV - 1));

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_bit #(
         .DB_SAMPLES (DB_SAMPLES)
      ) u_db (
         .clk     (clk),
         .rst     (rst),
         .tick    (tick),
         .key_raw (key_raw[i]),
         .level   (level[i])
      );
   end

   always_comb begin
      div_d        = tick ? '0 : div_q + DIV_W'(1);
      level_prev_d = level;
      rise         = level & ~level_prev_q;
`ifdef KEY_LOCKOUT_EN
      // A rising key has a low previous level, so any high previous level
      // belongs to another key that is already held.
      cand         = (|level_prev_q) ? '0 : rise;
`else
      cand         = rise;
`endif
      key_d        = lowest_set(cand);
      multi_d      = more_than_one(cand);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q        <= '0;
         level_prev_q <= '0;
         key_q        <= '0;
         multi_q      <= 1'b0;
      end else begin
         div_q        <= div_d;
         level_prev_q <= level_prev_d;
         key_q        <= key_d;
         multi_q      <= multi_d;
      end
   end

   assign key       = key_q;
   assign key_level = level;
   assign multi_hit = multi_q;

endmodule
